// File: rtl/dff_cfg_pkg.sv
// Shared constants, mode encoding and MISR step function for the configurable DFF bank.
package dff_cfg_pkg;

  localparam int unsigned MISR_W  = 32;
  localparam int unsigned COUNT_W = 16;
  localparam int unsigned MODE_W  = 2;

  localparam logic [MISR_W-1:0] MISR_SEED = 32'hFFFF_FFFF;
  // Feedback taps at bits 31, 21, 1 and 0
  localparam logic [MISR_W-1:0] MISR_TAPS = 32'h8020_0003;

  typedef enum logic [MODE_W-1:0] {
    MODE_LOAD  = 2'b00,
    MODE_SHIFT = 2'b01,
    MODE_ROT   = 2'b10,
    MODE_HOLD  = 2'b11
  } mode_e;

  function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0] sig,
                                                  input logic [MISR_W-1:0] fold);
    return {sig[MISR_W-2:0], ^(sig & MISR_TAPS)} ^ fold;
  endfunction

endpackage

// File: rtl/dff_cfg_misr.sv
// Folds the bank state into 32 bits and compresses it into a MISR with a saturating update count.
module dff_cfg_misr
  import dff_cfg_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     i_q,
  input  logic                 i_sig_en,
  input  logic                 i_sig_clr,
  output logic [MISR_W-1:0]    o_signature,
  output logic [COUNT_W-1:0]   o_sig_count
);

  localparam int unsigned N_CHUNK = (WIDTH + MISR_W - 1) / MISR_W;
  localparam int unsigned PAD_W   = N_CHUNK * MISR_W;

  logic [PAD_W-1:0]   w_pad;
  logic [MISR_W-1:0]  w_fold;
  logic [MISR_W-1:0]  r_sig;
  logic [COUNT_W-1:0] r_cnt;

  assign w_pad = PAD_W'(i_q);

  always_comb begin
    w_fold = '0;
    for (int k = 0; k < int'(N_CHUNK); k++) begin
      w_fold = w_fold ^ w_pad[k*MISR_W +: MISR_W];
    end
  end

  // Clear beats update; the signature keeps running after the count saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= MISR_SEED;
      r_cnt <= '0;
    end else if (i_sig_clr) begin
      r_sig <= MISR_SEED;
      r_cnt <= '0;
    end else if (i_sig_en) begin
      r_sig <= misr_next(r_sig, w_fold);
      if (r_cnt != {COUNT_W{1'b1}}) begin
        r_cnt <= r_cnt + COUNT_W'(1);
      end
    end
  end

  assign o_signature = r_sig;
  assign o_sig_count = r_cnt;

endmodule

// File: rtl/dff_cfg_bank.sv
// WIDTH-bit DFF bank with per-bit enable/sr polarity, sr and init values,
// load/shift/rotate/hold modes and a built-in MISR over the bank state.
module dff_cfg_bank
  import dff_cfg_pkg::*;
#(
  parameter int unsigned      WIDTH    = 64,
  parameter logic [WIDTH-1:0] INIT_VAL = '0,
  parameter logic [WIDTH-1:0] SR_VAL   = '0,
  parameter logic [WIDTH-1:0] EN_INV   = '0,
  parameter logic [WIDTH-1:0] SR_INV   = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                sr,
  input  logic [MODE_W-1:0]   mode,
  input  logic [WIDTH-1:0]    d,
  input  logic                shift_in,
  input  logic                sig_en,
  input  logic                sig_clr,
  output logic [WIDTH-1:0]    q,
  output logic                shift_out,
  output logic [MISR_W-1:0]   signature,
  output logic [COUNT_W-1:0]  sig_count
);

  mode_e            w_mode;
  logic [WIDTH-1:0] w_nxt;
  logic [WIDTH-1:0] r_q;

  assign w_mode = mode_e'(mode);

  for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_bit
    logic w_sr;
    logic w_en;
    logic w_nbr_shift;
    logic w_nbr_rot;
    logic w_act;

    assign w_sr = sr ^ SR_INV[gi];
    assign w_en = en ^ EN_INV[gi];

    // Neighbours always come from pre-edge state, regardless of their own enable/sr
    if (gi == 0) begin : g_lsb
      assign w_nbr_shift = shift_in;
      assign w_nbr_rot   = r_q[WIDTH-1];
    end else begin : g_upper
      assign w_nbr_shift = r_q[gi-1];
      assign w_nbr_rot   = r_q[gi-1];
    end

    always_comb begin
      w_act = r_q[gi];
      case (w_mode)
        MODE_LOAD:  w_act = d[gi];
        MODE_SHIFT: w_act = w_nbr_shift;
        MODE_ROT:   w_act = w_nbr_rot;
        default:    w_act = r_q[gi];
      endcase
    end

    assign w_nxt[gi] = w_sr ? SR_VAL[gi] : (w_en ? w_act : r_q[gi]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= INIT_VAL;
    end else begin
      r_q <= w_nxt;
    end
  end

  assign q         = r_q;
  assign shift_out = r_q[WIDTH-1];

  dff_cfg_misr #(
    .WIDTH (WIDTH)
  ) u_misr (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_q         (r_q),
    .i_sig_en    (sig_en),
    .i_sig_clr   (sig_clr),
    .o_signature (signature),
    .o_sig_count (sig_count)
  );

endmodule

// File: doc/dff_cfg_bank.md
Name: dff_cfg_bank

Overview:
Parametrised DFF bank that generalises single-primitive DFF conformance to WIDTH bits.
- Per-bit enable polarity, per-bit synchronous set/reset polarity, per-bit SR value and per-bit reset/INIT value.
- Four data modes: load, shift, rotate, hold.
- A built-in 32-bit MISR compresses the bank state so hardware runs can be signature-checked against simulation.
- Sits in verification designs as the device-under-test plus its own self-check.

Parameters:
WIDTH, 64, number of register bits (1..256)
INIT_VAL, {WIDTH{1'b0}}, per-bit value forced while rst_n low
SR_VAL, {WIDTH{1'b0}}, per-bit value loaded on synchronous set/reset
EN_INV, {WIDTH{1'b0}}, per-bit enable inversion mask
SR_INV, {WIDTH{1'b0}}, per-bit sr inversion mask

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
en  in  1  clock enable (raw, polarity per EN_INV)
sr  in  1  synchronous set/reset (raw, polarity per SR_INV)
mode  in  2  00 load, 01 shift left, 10 rotate left, 11 hold
d  in  WIDTH  parallel load data
shift_in  in  1  serial input into bit 0 in shift mode
sig_en  in  1  update signature this cycle
sig_clr  in  1  synchronous signature clear
q  out  WIDTH  register bank state
shift_out  out  1  combinational = q[WIDTH-1]
signature  out  32  MISR state
sig_count  out  16  number of signature updates, saturating

Behaviour:
- rst_n low (asynchronous, immediate): q=INIT_VAL, signature=32'hFFFF_FFFF, sig_count=0. Held while low; no edge-triggered updates occur.
- Per bit i, active sr: sr_i = sr ^ SR_INV[i].
- Per bit i, active enable: en_i = en ^ EN_INV[i].
- Per-bit priority at rising clk: sr_i -> q[i]=SR_VAL[i]; else en_i -> mode action; else hold. sr_i overrides en_i.
- mode 00: q[i] <= d[i].
- mode 01: q[i] <= q[i-1]; q[0] <= shift_in.
- mode 10: q[i] <= q[i-1]; q[0] <= q[WIDTH-1].
- mode 11: hold.
- Modes 01/10 always use pre-edge q. Bits held by a disabled enable or overridden by sr still feed their neighbours with their old values.
- WIDTH=1: shift loads shift_in; rotate holds.
- Fold: q zero-padded to a multiple of 32, 32-bit chunks XORed together.
- MISR feedback: fb = sig[31]^sig[21]^sig[1]^sig[0].
- MISR update: next = {sig[30:0], fb} ^ fold(q).
- MISR samples pre-edge q, i.e. the value visible in the same cycle as sig_en.
- sig_clr=1: signature=32'hFFFF_FFFF, sig_count=0. sig_clr wins over sig_en.
- sig_en=1 (no clr): signature updates; sig_count increments, saturating at 16'hFFFF (signature keeps updating after saturation).
- Latency: q, signature and sig_count change one edge after the inputs are sampled; shift_out follows q with zero latency.
- No X propagation: every flop is reset by rst_n.

Decomposition:
- Package dff_cfg_pkg holds:
  - mode enum (MODE_LOAD, MODE_SHIFT, MODE_ROT, MODE_HOLD)
  - MISR_W=32
  - MISR_SEED=32'hFFFF_FFFF
  - tap constant {31,21,1,0}
  - COUNT_W=16
- One sub-module, dff_cfg_misr: fold, MISR, saturating counter.
- The bit array is a generate loop in dff_cfg_bank.

Test Plan:
1. Reset. WIDTH=8, INIT_VAL=8'hA5, SR_VAL=8'h3C, EN_INV=8'h0F, SR_INV=8'hF0. Drop rst_n between edges -> q=8'hA5 without a clock, signature=32'hFFFF_FFFF, sig_count=0.
2. Per-bit polarity, same config, from q=8'hA5:
   - sr=1, en=0, mode=00, d=8'h5A -> q=8'hAC (bits 3:0 SR, bits 7:4 disabled).
   - Then sr=0, en=0 -> q=8'h3A (bits 7:4 SR, bits 3:0 enabled load).
3. Shift/rotate with masks=0, q=8'h81, en=1, sr=0:
   - mode=01, shift_in=0 -> q=8'h02, shift_out=0.
   - Reload 8'h81, mode=10 -> q=8'h03.
   - mode=11 -> q unchanged.
4. Reset mid-operation: in mode 01, assert rst_n low for 3 edges -> q stays 8'hA5, no shifting. Release -> shifting resumes on the first edge after release.
5. Signature: sig_clr with sig_en=1 -> signature=32'hFFFF_FFFF, count=0. Then sig_en for 10 cycles of random q -> signature and count=10 match the package-based reference model.
6. Saturation: 65 540 cycles of sig_en -> sig_count=16'hFFFF and holds; signature still matches the reference model.
